// File: rtl/biu_arb_pkg.sv
// ============================================================================
//  Module   : biu_arb_pkg
//  Purpose  : Shared types and transfer codes for the BIU arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package biu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_t;

  localparam logic [1:0] SEL_IDLE  = 2'b00;
  localparam logic [1:0] SEL_FETCH = 2'b11;
  localparam logic [1:0] SEL_DRD   = 2'b01;
  localparam logic [1:0] SEL_DWR   = 2'b10;

  function automatic logic [1:0] data_sel(input logic we);
    return we ? SEL_DWR : SEL_DRD;
  endfunction

endpackage

`default_nettype wire

// File: rtl/biu_arb_perf_cnt.sv
// ============================================================================
//  Module   : biu_arb_perf_cnt
//  Purpose  : 16-bit saturating wait-cycle counter (used under ARB_PERF_CNT_EN).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module biu_arb_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [15:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 16'h0000;
    end else if (inc && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 16'h0001;
    end
  end

endmodule

`default_nettype wire

// File: rtl/biu_arbiter.sv
// ============================================================================
//  Module   : biu_arbiter
//  Purpose  : Fetch/data arbiter for the shared 16-bit BIU port with fetch
//             lock and starvation limit. Optional macro: ARB_PERF_CNT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module biu_arbiter
  import biu_arb_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic              f_lock,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_done,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              biu_cs,
  output logic [1:0]        biu_sel,
  output logic [ADDR_W-1:0] biu_addr,
  output logic [DATA_W-1:0] biu_wdata,
  input  logic              biu_ready,
  input  logic [DATA_W-1:0] biu_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]       f_wait_cnt,
  output logic [15:0]       d_wait_cnt
`endif
);

  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       w_grant;
  owner_t     w_owner;
  logic       r_lock;
  logic [3:0] r_starve;

  assign f_rdata = biu_rdata;
  assign d_rdata = biu_rdata;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_owner     = OWNER_FETCH;
    f_done      = 1'b0;
    d_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_lock) begin
          w_grant = f_req;
        end else if (d_req && f_req && (r_starve == c_starve_limit)) begin
          w_grant = 1'b1;
        end else if (d_req) begin
          w_grant = 1'b1;
          w_owner = OWNER_DATA;
        end else if (f_req) begin
          w_grant = 1'b1;
        end
        if (w_grant) begin
          w_state_nxt = (w_owner == OWNER_DATA) ? BUSY_D : BUSY_F;
        end
      end
      BUSY_F: begin
        if (biu_ready) begin
          f_done      = !reset;
          w_state_nxt = IDLE;
        end
      end
      BUSY_D: begin
        if (biu_ready) begin
          d_done      = !reset;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      biu_cs    <= 1'b0;
      biu_sel   <= SEL_IDLE;
      biu_addr  <= '0;
      biu_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        biu_cs <= 1'b1;
        if (w_owner == OWNER_DATA) begin
          biu_sel   <= data_sel(d_we);
          biu_addr  <= d_addr;
          biu_wdata <= d_wdata;
        end else begin
          biu_sel  <= SEL_FETCH;
          biu_addr <= f_addr;
        end
      end else if (f_done || d_done) begin
        biu_cs  <= 1'b0;
        biu_sel <= SEL_IDLE;
      end
    end
  end

  // Lock drops if the fetch unit abandons its request, so data cannot deadlock.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock <= 1'b0;
    end else if (f_done) begin
      r_lock <= f_lock;
    end else if ((r_state == IDLE) && r_lock && !f_req) begin
      r_lock <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= 4'd0;
    end else if (w_grant) begin
      if ((w_owner == OWNER_FETCH) || !f_req) begin
        r_starve <= 4'd0;
      end else if (r_starve < c_starve_limit) begin
        r_starve <= r_starve + 4'd1;
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  biu_arb_perf_cnt u_f_wait (
    .clk   (clk),
    .reset (reset),
    .inc   (f_req && (r_state != BUSY_F)),
    .cnt   (f_wait_cnt)
  );

  biu_arb_perf_cnt u_d_wait (
    .clk   (clk),
    .reset (reset),
    .inc   (d_req && (r_state != BUSY_D)),
    .cnt   (d_wait_cnt)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_biu_arbiter.sv
// ============================================================================
//  Module   : tb_biu_arbiter
//  Purpose  : Directed self-checking bench for biu_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_biu_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        f_req = 1'b0, f_lock = 1'b0;
  logic [15:0] f_addr = '0;
  logic        f_done;
  logic [15:0] f_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [15:0] d_addr = '0, d_wdata = '0;
  logic        d_done;
  logic [15:0] d_rdata;
  logic        biu_cs;
  logic [1:0]  biu_sel;
  logic [15:0] biu_addr, biu_wdata;
  logic        biu_ready = 1'b0;
  logic [15:0] biu_rdata = '0;
`ifdef ARB_PERF_CNT_EN
  logic [15:0] f_wait_cnt, d_wait_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  biu_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_lock(f_lock), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done),
    .d_rdata(d_rdata), .biu_cs(biu_cs), .biu_sel(biu_sel), .biu_addr(biu_addr),
    .biu_wdata(biu_wdata), .biu_ready(biu_ready), .biu_rdata(biu_rdata)
`ifdef ARB_PERF_CNT_EN
    , .f_wait_cnt(f_wait_cnt), .d_wait_cnt(d_wait_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    biu_ready = 1'b1;
    tick(); tick();
    n_cmp++; if (biu_cs !== 1'b0) begin n_fail++; $display("FAIL rst_cs got %b want 0", biu_cs); end
    n_cmp++; if (biu_sel !== 2'b00) begin n_fail++; $display("FAIL rst_sel got %b want 00", biu_sel); end
    n_cmp++; if (biu_addr !== 16'h0) begin n_fail++; $display("FAIL rst_addr got %h want 0000", biu_addr); end
    n_cmp++; if (biu_wdata !== 16'h0) begin n_fail++; $display("FAIL rst_wdata got %h want 0000", biu_wdata); end
    n_cmp++; if ({f_done, d_done} !== 2'b00) begin n_fail++; $display("FAIL rst_done got %b want 00", {f_done, d_done}); end
    reset = 1'b0;
    biu_ready = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    f_req = 1'b1; f_addr = 16'h0010;
    tick();
    n_cmp++; if (biu_cs !== 1'b1) begin n_fail++; $display("FAIL f1_cs got %b want 1", biu_cs); end
    n_cmp++; if (biu_sel !== 2'b11) begin n_fail++; $display("FAIL f1_sel got %b want 11", biu_sel); end
    n_cmp++; if (biu_addr !== 16'h0010) begin n_fail++; $display("FAIL f1_addr got %h want 0010", biu_addr); end
    n_cmp++; if (f_done !== 1'b0) begin n_fail++; $display("FAIL f1_early_done got %b want 0", f_done); end
    biu_ready = 1'b1; biu_rdata = 16'hA5A5;
    #1;
    n_cmp++; if (f_done !== 1'b1) begin n_fail++; $display("FAIL f1_done got %b want 1", f_done); end
    n_cmp++; if (f_rdata !== 16'hA5A5) begin n_fail++; $display("FAIL f1_rdata got %h want a5a5", f_rdata); end
    n_cmp++; if (d_done !== 1'b0) begin n_fail++; $display("FAIL f1_d_done got %b want 0", d_done); end
    tick();
    f_req = 1'b0; biu_ready = 1'b0;
    #1;
    n_cmp++; if ({biu_cs, biu_sel, f_done} !== 4'b0000) begin n_fail++; $display("FAIL f1_idle got %b want 0000", {biu_cs, biu_sel, f_done}); end
    tick();
    n_cmp++; if (biu_cs !== 1'b0) begin n_fail++; $display("FAIL f1_no_regrant got %b want 0", biu_cs); end
  endtask

  task automatic test_data_priority();
    f_req = 1'b1; f_addr = 16'h0020;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234;
    tick();
    n_cmp++; if (biu_sel !== 2'b10) begin n_fail++; $display("FAIL p_sel got %b want 10", biu_sel); end
    n_cmp++; if (biu_addr !== 16'h0200) begin n_fail++; $display("FAIL p_addr got %h want 0200", biu_addr); end
    n_cmp++; if (biu_wdata !== 16'h1234) begin n_fail++; $display("FAIL p_wdata got %h want 1234", biu_wdata); end
    biu_ready = 1'b1;
    #1;
    n_cmp++; if ({f_done, d_done} !== 2'b01) begin n_fail++; $display("FAIL p_ddone got %b want 01", {f_done, d_done}); end
    tick();
    d_req = 1'b0; biu_ready = 1'b0;
    #1;
    n_cmp++; if (biu_cs !== 1'b0) begin n_fail++; $display("FAIL p_gap got %b want 0", biu_cs); end
    tick();
    n_cmp++; if ({biu_cs, biu_sel} !== 3'b111) begin n_fail++; $display("FAIL p_fsel got %b want 111", {biu_cs, biu_sel}); end
    n_cmp++; if (biu_addr !== 16'h0020) begin n_fail++; $display("FAIL p_faddr got %h want 0020", biu_addr); end
    biu_ready = 1'b1;
    #1;
    n_cmp++; if ({f_done, d_done} !== 2'b10) begin n_fail++; $display("FAIL p_fdone got %b want 10", {f_done, d_done}); end
    tick();
    f_req = 1'b0; biu_ready = 1'b0;
    tick();
  endtask

  task automatic test_lock();
    f_req = 1'b1; f_lock = 1'b1; f_addr = 16'h0030;
    tick();
    n_cmp++; if ({biu_sel, biu_addr} !== {2'b11, 16'h0030}) begin n_fail++; $display("FAIL l_beat1 got %b/%h want 11/0030", biu_sel, biu_addr); end
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300;
    biu_ready = 1'b1; biu_rdata = 16'h1111;
    #1;
    n_cmp++; if (f_done !== 1'b1) begin n_fail++; $display("FAIL l_done1 got %b want 1", f_done); end
    tick();
    f_addr = 16'h0031; f_lock = 1'b0; biu_ready = 1'b0;
    tick();
    n_cmp++; if ({biu_sel, biu_addr} !== {2'b11, 16'h0031}) begin n_fail++; $display("FAIL l_beat2 got %b/%h want 11/0031", biu_sel, biu_addr); end
    biu_ready = 1'b1; biu_rdata = 16'h2222;
    #1;
    n_cmp++; if ({f_done, d_done} !== 2'b10) begin n_fail++; $display("FAIL l_done2 got %b want 10", {f_done, d_done}); end
    tick();
    f_req = 1'b0; biu_ready = 1'b0;
    tick();
    n_cmp++; if ({biu_sel, biu_addr} !== {2'b01, 16'h0300}) begin n_fail++; $display("FAIL l_data got %b/%h want 01/0300", biu_sel, biu_addr); end
    biu_ready = 1'b1; biu_rdata = 16'h5A5A;
    #1;
    n_cmp++; if ({d_done, d_rdata} !== {1'b1, 16'h5A5A}) begin n_fail++; $display("FAIL l_drd got %b/%h want 1/5a5a", d_done, d_rdata); end
    tick();
    d_req = 1'b0; biu_ready = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    logic [1:0] exp_sel [6];
    exp_sel[0] = 2'b10; exp_sel[1] = 2'b10; exp_sel[2] = 2'b10;
    exp_sel[3] = 2'b10; exp_sel[4] = 2'b11; exp_sel[5] = 2'b10;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0400; d_wdata = 16'h0BEE;
    f_req = 1'b1; f_addr = 16'h0040;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_cmp++;
      if ({biu_cs, biu_sel} !== {1'b1, exp_sel[k]}) begin
        n_fail++; $display("FAIL s_grant%0d got %b want %b", k, {biu_cs, biu_sel}, {1'b1, exp_sel[k]});
      end
      biu_ready = 1'b1;
      #1;
      n_cmp++;
      if ({f_done, d_done} !== ((exp_sel[k] == 2'b11) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL s_done%0d got %b", k, {f_done, d_done});
      end
      tick();
      biu_ready = 1'b0;
      if (exp_sel[k] == 2'b11) f_req = 1'b0;
      if (k == 5) d_req = 1'b0;
    end
    tick();
  endtask

  task automatic test_reset_midxfer();
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0500; d_wdata = 16'h7777;
    tick();
    n_cmp++; if ({biu_cs, biu_sel} !== 3'b110) begin n_fail++; $display("FAIL r_busy got %b want 110", {biu_cs, biu_sel}); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_cmp++; if ({biu_cs, biu_sel, d_done} !== 4'b0000) begin n_fail++; $display("FAIL r_abort got %b want 0000", {biu_cs, biu_sel, d_done}); end
    tick();
    n_cmp++; if ({biu_cs, biu_sel, biu_addr} !== {3'b110, 16'h0500}) begin n_fail++; $display("FAIL r_regrant got %b/%h want 110/0500", {biu_cs, biu_sel}, biu_addr); end
    biu_ready = 1'b1;
    #1;
    n_cmp++; if (d_done !== 1'b1) begin n_fail++; $display("FAIL r_done got %b want 1", d_done); end
    tick();
    d_req = 1'b0; biu_ready = 1'b0;
    tick();
  endtask

`ifdef ARB_PERF_CNT_EN
  task automatic test_perf_cnt();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_cmp++; if ({f_wait_cnt, d_wait_cnt} !== 32'h0) begin n_fail++; $display("FAIL pc_rst got %h/%h want 0/0", f_wait_cnt, d_wait_cnt); end
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0600;
    f_req = 1'b1; f_addr = 16'h0060;
    tick();
    tick(); tick(); tick();
    biu_ready = 1'b1;
    tick();
    d_req = 1'b0; biu_ready = 1'b0;
    tick();
    n_cmp++; if (biu_sel !== 2'b11) begin n_fail++; $display("FAIL pc_fgrant got %b want 11", biu_sel); end
    n_cmp++; if (f_wait_cnt !== 16'd6) begin n_fail++; $display("FAIL pc_fwait got %0d want 6", f_wait_cnt); end
    n_cmp++; if (d_wait_cnt !== 16'd1) begin n_fail++; $display("FAIL pc_dwait got %0d want 1", d_wait_cnt); end
    biu_ready = 1'b1;
    tick();
    f_req = 1'b0; biu_ready = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_data_priority();
    test_lock();
    test_starvation();
    test_reset_midxfer();
`ifdef ARB_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
